// File: rtl/ctrl_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding and the
// RV32 func3 size codes that travel with each memory request.
package ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DROP_I = 2'd3
    } arb_state_t;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // Starvation limit range is 1..15, so four bits always hold it.
    localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of data grants made while a fetch was waiting.
// at_limit tells the arbiter to hand the next slot to fetch.
module arb_starve_cnt
    import ctrl_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(LIMIT);

    logic [STARVE_W-1:0] count;

    // Increment wins over clear; the count saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            if (count != LIMIT_V)
                count <= count + STARVE_W'(1);
        end else if (clr) begin
            count <= '0;
        end
    end

    assign at_limit = (count == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between instruction fetch and data
// access. Data has priority, with a starvation guard for fetch; flushed
// fetches are completed on the memory side and their response dropped.
// Optional watchdog: define ARB_TIMEOUT_EN to abort transactions whose
// mem_ack does not arrive within TIMEOUT cycles (mem_err pulses).
module mem_port_arbiter
    import ctrl_pkg::*;
#(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_ack,
    output logic [DWIDTH-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_size,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic [DWIDTH-1:0] d_wdata,
    output logic              d_ack,
    output logic [DWIDTH-1:0] d_rdata,
    output logic              stall_f,
    output logic              stall_m,
    output logic              mem_req,
    output logic              mem_we,
    output logic [2:0]        mem_size,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              mem_err
);

    arb_state_t state, state_next;

    logic grant_d;
    logic grant_i;
    logic starve_inc;
    logic starve_clr;
    logic at_limit;
    logic timeout;
    logic done;

    arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .at_limit (at_limit)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_cnt;

    // Count cycles spent waiting on the memory; restarts every transaction.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    assign timeout = (state != IDLE) && !mem_ack &&
                     (wait_cnt == WAIT_W'(TIMEOUT - 1));
`else
    // Without the watchdog a transaction waits for mem_ack forever; the
    // comparison keeps TIMEOUT referenced and always evaluates to 0.
    assign timeout = (TIMEOUT < 0);
`endif

    assign done = mem_ack || timeout;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Arbitration, completion, flush handling and starvation bookkeeping.
    always_comb begin
        state_next = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        d_ack      = 1'b0;
        i_ack      = 1'b0;
        case (state)
            IDLE: begin
                if (!i_req)
                    starve_clr = 1'b1;
                if (d_req && !(i_req && at_limit)) begin
                    grant_d    = 1'b1;
                    starve_inc = i_req;
                    state_next = BUSY_D;
                end else if (i_req && !i_flush) begin
                    grant_i    = 1'b1;
                    starve_clr = 1'b1;
                    state_next = BUSY_I;
                end
            end
            BUSY_D: begin
                if (done) begin
                    d_ack      = 1'b1;
                    state_next = IDLE;
                end
            end
            BUSY_I: begin
                if (done) begin
                    i_ack      = !i_flush;
                    state_next = IDLE;
                end else if (i_flush) begin
                    state_next = DROP_I;
                end
            end
            DROP_I: begin
                if (done)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            d_ack = 1'b0;
            i_ack = 1'b0;
        end
    end

    // Registered memory request: loaded on a grant, released on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_size  <= 3'b000;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_size  <= d_size;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
        end else if (grant_i) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_size  <= SZ_W;
            mem_addr  <= i_addr;
        end else if (state != IDLE && done) begin
            mem_req   <= 1'b0;
        end
    end

    assign d_rdata = timeout ? '0 : mem_rdata;
    assign i_rdata = timeout ? '0 : mem_rdata;
    assign mem_err = timeout && !rst;

    assign stall_m = d_req && !d_ack;
    assign stall_f = (i_req && !i_ack) || stall_m;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. The memory side is
// driven by hand, one cycle at a time, with expected values worked out
// from the intended cycle behaviour of the arbiter.
module tb_mem_port_arbiter;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_flush;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        stall_f;
    logic        stall_m;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .AWIDTH       (32),
        .DWIDTH       (32),
        .STARVE_LIMIT (4),
        .TIMEOUT      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_flush   (i_flush),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_size    (d_size),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .stall_f   (stall_f),
        .stall_m   (stall_m),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ack, input logic [31:0] rdata);
        mem_ack   = ack;
        mem_rdata = rdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_size = 3'b000; d_addr = '0; d_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 32'h0);
        checkOutput("rst_state", dut.state, IDLE);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_acks", {i_ack, d_ack, mem_err}, 0);
        rst = 1'b0;

        // Single fetch, ack three cycles after mem_req rises.
        nextCycle();
        i_req = 1'b1; i_addr = 32'h100;
        applyStimulus(1'b0, 32'h0);
        checkOutput("f1_stall_c0", stall_f, 1);
        nextCycle();
        applyStimulus(1'b0, 32'h0);
        checkOutput("f1_mem_req", mem_req, 1);
        checkOutput("f1_mem_addr", mem_addr, 32'h100);
        checkOutput("f1_mem_we", mem_we, 0);
        checkOutput("f1_mem_size", mem_size, SZ_W);
        checkOutput("f1_stall_c1", stall_f, 1);
        nextCycle();
        applyStimulus(1'b0, 32'h0);
        checkOutput("f1_stall_c2", stall_f, 1);
        checkOutput("f1_no_ack_c2", i_ack, 0);
        nextCycle();
        applyStimulus(1'b0, 32'h0);
        checkOutput("f1_stall_c3", stall_f, 1);
        nextCycle();
        applyStimulus(1'b1, 32'h00500093);
        checkOutput("f1_i_ack", i_ack, 1);
        checkOutput("f1_i_rdata", i_rdata, 32'h00500093);
        checkOutput("f1_stall_ack", stall_f, 0);
        checkOutput("f1_d_ack", d_ack, 0);
        nextCycle();
        i_req = 1'b0;
        applyStimulus(1'b0, 32'h0);
        checkOutput("f1_idle", dut.state, IDLE);
        checkOutput("f1_req_drop", mem_req, 0);
        checkOutput("f1_ack_pulse", i_ack, 0);

        // Simultaneous fetch and store: data first, then fetch.
        i_req = 1'b1; i_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b1; d_size = SZ_H; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
        applyStimulus(1'b0, 32'h0);
        checkOutput("pr_stall_m", stall_m, 1);
        checkOutput("pr_stall_f", stall_f, 1);
        nextCycle();
        applyStimulus(1'b0, 32'h0);
        checkOutput("pr_state_d", dut.state, BUSY_D);
        checkOutput("pr_mem_we", mem_we, 1);
        checkOutput("pr_mem_size", mem_size, SZ_H);
        checkOutput("pr_mem_addr", mem_addr, 32'h2000);
        checkOutput("pr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        applyStimulus(1'b1, 32'h0);
        checkOutput("pr_d_ack", d_ack, 1);
        checkOutput("pr_i_ack", i_ack, 0);
        checkOutput("pr_stall_m_ack", stall_m, 0);
        checkOutput("pr_stall_f_ack", stall_f, 1);
        nextCycle();
        d_req = 1'b0; d_we = 1'b0;
        applyStimulus(1'b0, 32'h0);
        checkOutput("pr_bubble", mem_req, 0);
        nextCycle();
        applyStimulus(1'b0, 32'h0);
        checkOutput("pr_state_i", dut.state, BUSY_I);
        checkOutput("pr_f_addr", mem_addr, 32'h104);
        checkOutput("pr_f_we", mem_we, 0);
        applyStimulus(1'b1, 32'h11111111);
        checkOutput("pr_f_ack", i_ack, 1);
        checkOutput("pr_f_rdata", i_rdata, 32'h11111111);
        nextCycle();
        i_req = 1'b0;
        applyStimulus(1'b0, 32'h0);

        // Data held continuously against a waiting fetch.
        i_req = 1'b1; i_addr = 32'h108;
        d_req = 1'b1; d_we = 1'b0; d_size = SZ_W; d_addr = 32'h3000;
        applyStimulus(1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            applyStimulus(1'b0, 32'h0);
            checkOutput($sformatf("st_grant_d%0d", k), dut.state, BUSY_D);
            applyStimulus(1'b1, 32'h40 + k);
            checkOutput($sformatf("st_d_ack%0d", k), d_ack, 1);
            checkOutput($sformatf("st_d_rdata%0d", k), d_rdata, 32'h40 + k);
            nextCycle();
            applyStimulus(1'b0, 32'h0);
            checkOutput($sformatf("st_idle%0d", k), dut.state, IDLE);
        end
        checkOutput("st_cnt_limit", dut.u_starve.count, 4);
        nextCycle();
        applyStimulus(1'b0, 32'h0);
        checkOutput("st_fetch_grant", dut.state, BUSY_I);
        checkOutput("st_fetch_addr", mem_addr, 32'h108);
        checkOutput("st_cnt_clear", dut.u_starve.count, 0);
        applyStimulus(1'b1, 32'h22222222);
        checkOutput("st_i_ack", i_ack, 1);
        checkOutput("st_stall_m", stall_m, 1);
        nextCycle();
        d_req = 1'b0; i_req = 1'b0;
        applyStimulus(1'b0, 32'h0);
        checkOutput("st_done_idle", dut.state, IDLE);

        // Flush of an outstanding fetch.
        i_req = 1'b1; i_addr = 32'h10C;
        nextCycle();
        i_flush = 1'b1;
        applyStimulus(1'b0, 32'h0);
        checkOutput("fl_busy", dut.state, BUSY_I);
        nextCycle();
        i_flush = 1'b0; i_req = 1'b0;
        applyStimulus(1'b0, 32'h0);
        checkOutput("fl_drop", dut.state, DROP_I);
        checkOutput("fl_req_held", mem_req, 1);
        nextCycle();
        applyStimulus(1'b1, 32'h33333333);
        checkOutput("fl_no_ack", {i_ack, d_ack}, 0);
        nextCycle();
        applyStimulus(1'b0, 32'h0);
        checkOutput("fl_idle", dut.state, IDLE);
        checkOutput("fl_req_drop", mem_req, 0);
        i_req = 1'b1; i_addr = 32'h200;
        nextCycle();
        applyStimulus(1'b0, 32'h0);
        checkOutput("fl_new_addr", mem_addr, 32'h200);
        applyStimulus(1'b1, 32'hCAFE0001);
        checkOutput("fl_new_ack", i_ack, 1);
        checkOutput("fl_new_rdata", i_rdata, 32'hCAFE0001);
        nextCycle();
        applyStimulus(1'b0, 32'h0);

        // Flush coincident with mem_ack suppresses the fetch ack.
        i_addr = 32'h204;
        nextCycle();
        i_flush = 1'b1;
        applyStimulus(1'b1, 32'h44444444);
        checkOutput("fc_no_ack", i_ack, 0);
        nextCycle();
        applyStimulus(1'b0, 32'h0);
        checkOutput("fc_idle", dut.state, IDLE);

        // Flush in IDLE blocks the fetch grant for that cycle.
        nextCycle();
        applyStimulus(1'b0, 32'h0);
        checkOutput("fi_blocked", dut.state, IDLE);
        checkOutput("fi_no_req", mem_req, 0);
        i_flush = 1'b0;
        nextCycle();
        applyStimulus(1'b0, 32'h0);
        checkOutput("fi_granted", dut.state, BUSY_I);
        applyStimulus(1'b1, 32'h55555555);
        nextCycle();
        i_req = 1'b0;
        applyStimulus(1'b0, 32'h0);

        // Stray mem_ack in IDLE is ignored.
        applyStimulus(1'b1, 32'h66666666);
        checkOutput("ia_no_ack", {i_ack, d_ack}, 0);
        nextCycle();
        applyStimulus(1'b0, 32'h0);
        checkOutput("ia_idle", dut.state, IDLE);

        // Reset while a data access is outstanding.
        d_req = 1'b1; d_we = 1'b0; d_size = SZ_W; d_addr = 32'h4000;
        nextCycle();
        applyStimulus(1'b0, 32'h0);
        checkOutput("rb_busy", dut.state, BUSY_D);
        nextCycle();
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0);
        nextCycle();
        rst = 1'b0; d_req = 1'b0;
        applyStimulus(1'b0, 32'h0);
        checkOutput("rb_idle", dut.state, IDLE);
        checkOutput("rb_mem_req", mem_req, 0);
        applyStimulus(1'b1, 32'h77777777);
        checkOutput("rb_late_ack", d_ack, 0);
        checkOutput("rb_no_err", mem_err, 0);
        nextCycle();
        applyStimulus(1'b0, 32'h0);

`ifdef ARB_TIMEOUT_EN
        // Watchdog: no mem_ack for eight busy cycles.
        d_req = 1'b1; d_addr = 32'h5000;
        nextCycle();
        for (int n = 0; n < 7; n++) begin
            applyStimulus(1'b0, 32'h88888888);
            checkOutput($sformatf("to_wait%0d", n), {mem_err, d_ack}, 0);
            nextCycle();
        end
        applyStimulus(1'b0, 32'h88888888);
        checkOutput("to_err", mem_err, 1);
        checkOutput("to_d_ack", d_ack, 1);
        checkOutput("to_rdata", d_rdata, 0);
        nextCycle();
        d_req = 1'b0;
        applyStimulus(1'b0, 32'h0);
        checkOutput("to_idle", dut.state, IDLE);
        checkOutput("to_err_pulse", mem_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares a single unified memory port between instruction fetch (IF stage) and data access (MEM stage) of the pipelined RV32 core.
- Data has fixed priority over fetch, with a starvation guard for fetch.
- Supports variable-latency memory through a req/ack handshake, and discards fetch responses cancelled by a pipeline flush.
- Produces stall requests for the IF and MEM stages.

Parameters:
- AWIDTH, 32, address width
- DWIDTH, 32, data width
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits; range 1..15
- TIMEOUT, 64, cycles to wait for mem_ack (used only with the optional feature)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held stable until i_ack or flush
- i_addr  in  AWIDTH  fetch address
- i_flush  in  1  pipeline flush; cancels the pending or outstanding fetch
- i_ack  out  1  fetch response valid (1-cycle pulse)
- i_rdata  out  DWIDTH  fetch data, valid with i_ack
- d_req  in  1  data request; held stable until d_ack
- d_we  in  1  1 = store, 0 = load
- d_size  in  3  func3 size/sign code
- d_addr  in  AWIDTH  data address
- d_wdata  in  DWIDTH  store data
- d_ack  out  1  data response valid (1-cycle pulse)
- d_rdata  out  DWIDTH  load data, valid with d_ack
- stall_f  out  1  hold IF stage
- stall_m  out  1  hold MEM stage and everything behind it
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_size  out  3  memory size code
- mem_addr  out  AWIDTH  memory address
- mem_wdata  out  DWIDTH  memory write data
- mem_ack  in  1  memory completion, 1 cycle
- mem_rdata  in  DWIDTH  read data, valid with mem_ack
- mem_err  out  1  timeout flag (only with the optional feature, else tied 0)

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D, DROP_I.
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_size=0, mem_addr=0, mem_wdata=0, starve_cnt=0, i_ack=0, d_ack=0, mem_err=0.
- IDLE arbitration:
  - d_req && !(i_req && starve_cnt==STARVE_LIMIT) -> BUSY_D.
  - else i_req && !i_flush -> BUSY_I.
  - else stay in IDLE.
- On grant, register addr/we/size/wdata into the mem_* outputs and assert mem_req the next cycle (registered outputs). Fetch grants force mem_we=0 and mem_size=3'b010.
- mem_req stays high in BUSY_*. The memory may assert mem_ack in the first BUSY cycle or any later cycle.
- Completion in BUSY_D: mem_ack -> d_ack=1 and d_rdata=mem_rdata, both combinational in the same cycle; mem_req drops; next state IDLE.
- Completion in BUSY_I: mem_ack -> i_ack=1 and i_rdata=mem_rdata; next state IDLE.
- Minimum latency is 2 cycles from request to ack. There is one IDLE bubble between transactions.
- Flush of an outstanding fetch: i_flush in BUSY_I without mem_ack -> DROP_I.
  - The transaction completes on the memory side.
  - On mem_ack, i_ack stays 0 and the state goes to IDLE.
  - i_flush coincident with mem_ack -> ack suppressed.
- Flush in IDLE: i_req is ignored that cycle.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each data grant made while i_req is high.
  - Clears on any fetch grant, and whenever i_req is low in IDLE.
- Stall outputs:
  - stall_m = d_req && !d_ack.
  - stall_f = (i_req && !i_ack) || stall_m.
  - Both are combinational.
- d_ack and i_ack are never high in the same cycle.
- mem_ack while in IDLE is ignored.
- rst in any state returns to IDLE in the same edge. Any in-flight memory response after reset is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A wait counter runs in BUSY_*/DROP_I.
  - If it reaches TIMEOUT without mem_ack, the FSM returns to IDLE and mem_err pulses 1 cycle.
  - The owning requester receives its ack with rdata=0 (DROP_I: no ack).
- When undefined: no counter, mem_err tied 0, and the FSM waits indefinitely.

Decomposition:
- Shared package (ctrl_pkg):
  - FSM state encoding (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2, DROP_I=2'd3).
  - Size code constants (SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b010, SZ_BU=3'b100, SZ_HU=3'b101).
- One sub-module, arb_starve_cnt: the saturating starvation counter with clear/increment and an at_limit output.

Test Plan:
- Single fetch, addr 0x100, mem_ack 3 cycles after mem_req, rdata 0x00500093 -> i_ack one cycle with i_rdata=0x00500093; stall_f high for 4 cycles.
- i_req and d_req together, store addr 0x2000, wdata 0xDEADBEEF -> data granted first: mem_we=1, mem_size=d_size, d_ack; then fetch granted.
- d_req held continuously with i_req pending, STARVE_LIMIT=4 -> 4 data grants, then fetch granted; starve_cnt returns to 0.
- i_flush one cycle after fetch grant, mem_ack 2 cycles later -> no i_ack; state returns to IDLE; a new i_req at 0x200 completes normally.
- rst asserted while in BUSY_D -> next cycle mem_req=0 and state IDLE; a late mem_ack produces no d_ack.
- With ARB_TIMEOUT_EN, TIMEOUT=8, and no mem_ack -> after 8 cycles mem_err pulses, d_ack pulses with d_rdata=0, FSM goes IDLE.
